// File: rtl/alu_share_ctrl.sv
// Round-robin share of one external single-cycle ALU between two requesters; result registered.
// Latency: accept edge T, rsp_valid from edge T+1; RESP holds until rsp_ready, no new accepts meanwhile.
module alu_share_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [2:0]       r0_op,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r1_op,
  output logic             r1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zero,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } req_t;

  state_t state;
  req_t   req_q;
  logic   ptr;
  logic   gnt0;
  logic   gnt1;

  // ptr names the requester that wins a tie
  always_comb begin
    gnt0 = (state == IDLE) && r0_valid && (!r1_valid || !ptr);
    gnt1 = (state == IDLE) && r1_valid && (!r0_valid || ptr);
  end

  assign r0_ready  = gnt0;
  assign r1_ready  = gnt1;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  // Outside EXEC the ALU sees a no-op so its result idles at zero
  assign alu_a  = (state == EXEC) ? req_q.a : '0;
  assign alu_b  = (state == EXEC) ? req_q.b : '0;
  assign alu_op = (state == EXEC && !rsp_err) ? req_q.op : 3'd7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= '0;
      ptr      <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_res  <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            req_q.a  <= gnt1 ? r1_a : r0_a;
            req_q.b  <= gnt1 ? r1_b : r0_b;
            req_q.op <= gnt1 ? r1_op : r0_op;
            rsp_id   <= gnt1;
            rsp_err  <= gnt1 ? (r1_op inside {3'd4, 3'd5, 3'd6})
                             : (r0_op inside {3'd4, 3'd5, 3'd6});
            state    <= EXEC;
          end
        end
        EXEC: begin
          // Illegal opcodes report a clean zero regardless of the ALU
          rsp_res  <= rsp_err ? '0 : alu_res;
          rsp_zero <= rsp_err | alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            ptr   <= ~rsp_id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU attached to its operand port.
module tb_alu_share_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         r0_valid, r1_valid, r0_ready, r1_ready;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]   r0_op, r1_op;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_op;
  logic         alu_zero;
  logic         rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready, busy;
  logic [W-1:0] rsp_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_ready(r1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
  );

  always_comb begin
    case (alu_op)
      3'd0:    alu_res = alu_a + alu_b;
      3'd1:    alu_res = alu_a - alu_b;
      3'd2:    alu_res = alu_a & alu_b;
      3'd3:    alu_res = alu_a | alu_b;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Idle-state outputs: readies, response, busy and ALU drive {ready0,ready1,valid,id,zero,err,busy}
  task automatic chk_reset_outs(input string tag);
    chk({tag, " flags"}, {25'd0, r0_ready, r1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err, busy}, '0);
    chk({tag, " rsp_res"}, rsp_res, '0);
    chk({tag, " alu_ab"}, alu_a | alu_b, '0);
    chk({tag, " alu_op"}, {29'd0, alu_op}, 32'd7);
  endtask

  // Single transaction from an idle start at posedge+1; ends at posedge+1 back in IDLE
  task automatic do_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W-1:0] exp_res,
                        input logic exp_zero, input logic exp_err);
    if (id) begin r1_valid = 1; r1_a = a; r1_b = b; r1_op = op; end
    else    begin r0_valid = 1; r0_a = a; r0_b = b; r0_op = op; end
    @(negedge clk);
    chk("grant", {30'd0, r1_ready, r0_ready}, id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0;
    chk("exec busy/valid", {30'd0, busy, rsp_valid}, 32'd2);
    chk("exec alu_a", alu_a, a);
    chk("exec alu_op", {29'd0, alu_op}, exp_err ? 32'd7 : {29'd0, op});
    @(posedge clk); #1;
    chk("rsp flags", {28'd0, rsp_valid, rsp_id, rsp_zero, rsp_err},
        {28'd0, 1'b1, id, exp_zero, exp_err});
    chk("rsp_res", rsp_res, exp_res);
    @(posedge clk); #1;
    chk("back idle", {30'd0, busy, rsp_valid}, '0);
  endtask

  initial begin
    rst_n = 0; rsp_ready = 1;
    r0_valid = 0; r1_valid = 0;
    r0_a = '0; r0_b = '0; r0_op = '0; r1_a = '0; r1_b = '0; r1_op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1;
    @(posedge clk); #1;

    do_req(0, 32'd5, 32'd3, 3'd0, 32'd8, 0, 0);
    do_req(1, 32'd7, 32'd7, 3'd1, 32'd0, 1, 0);
    do_req(1, 32'hF0, 32'h3C, 3'd3, 32'hFC, 0, 0);

    // Continuous tie: expect 0,1,0,1 with a grant every third cycle
    r0_valid = 1; r0_a = 32'd1;  r0_b = 32'd2; r0_op = 3'd0;
    r1_valid = 1; r1_a = 32'd10; r1_b = 32'd4; r1_op = 3'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tie grant", {30'd0, r1_ready, r0_ready}, (k % 2) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("tie rsp_id", {31'd0, rsp_id}, k % 2);
      chk("tie rsp_res", rsp_res, (k % 2) ? 32'd6 : 32'd3);
      @(posedge clk); #1;
    end
    r0_valid = 0; r1_valid = 0;

    do_req(0, 32'd5, 32'd3, 3'd5, 32'd0, 1, 1);

    // Stalled response with a competing request pending
    rsp_ready = 0;
    r1_valid = 1; r1_a = 32'd2; r1_b = 32'd1; r1_op = 3'd0;
    @(posedge clk); #1;
    r1_valid = 0;
    @(posedge clk); #1;
    r0_valid = 1; r0_a = 32'd4; r0_b = 32'd4; r0_op = 3'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall flags", {25'd0, rsp_valid, rsp_id, rsp_zero, rsp_err, busy, r0_ready, r1_ready},
          32'b110_0100);
      chk("stall rsp_res", rsp_res, 32'd3);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("release idle", {30'd0, busy, rsp_valid}, '0);
    chk("release grant", {30'd0, r1_ready, r0_ready}, 32'd1);
    r0_valid = 0;
    @(posedge clk); #1;
    chk("dropped valid", {31'd0, busy}, '0);

    // Leave pointer at 1, then abort an r1 transaction in EXEC
    do_req(0, 32'd9, 32'd1, 3'd1, 32'd8, 0, 0);
    r1_valid = 1; r1_a = 32'd3; r1_b = 32'd3; r1_op = 3'd0;
    @(posedge clk); #1;
    r1_valid = 0;
    chk("abort exec busy", {31'd0, busy}, 32'd1);
    rst_n = 0;
    #1;
    chk_reset_outs("abort");
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort no rsp", {30'd0, rsp_valid, busy}, '0);
    end
    r0_valid = 1; r1_valid = 1;
    @(negedge clk);
    chk("post-reset tie", {30'd0, r1_ready, r0_ready}, 32'd1);
    r0_valid = 0; r1_valid = 0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded expected bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester controller that time-shares the single-cycle ALU datapath between independent clients, e.g. the main instruction path and a diagnostic/self-test engine. It arbitrates round-robin, latches the winning operands, drives the external ALU for exactly one cycle, and returns a registered result on a shared response channel with valid/ready flow control. The ALU stays a separate instance; this block only drives its operand and opcode inputs and samples its result and zero outputs.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- r0_valid  in  1  requester 0 has an operation pending
- r0_a, r0_b  in  WIDTH  requester 0 operands
- r0_op  in  3  requester 0 ALU opcode (0 add, 1 sub, 2 and, 3 or, 7 deactive)
- r0_ready  out  1  requester 0 transaction accepted this cycle
- r1_valid, r1_a, r1_b, r1_op, r1_ready: same as r0_*, requester 1
- alu_a, alu_b  out  WIDTH  operands to the ALU
- alu_op  out  3  opcode to the ALU
- alu_res  in  WIDTH  ALU result (combinational)
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response available
- rsp_id  out  1  requester index owning the response
- rsp_res  out  WIDTH  captured result
- rsp_zero  out  1  captured zero flag
- rsp_err  out  1  request carried an illegal opcode (4, 5, 6)
- rsp_ready  in  1  response consumer accepts
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If neither valid is high, remain in IDLE.
  - Otherwise select a winner: if only one valid is high, that requester wins; if both are high, the requester indicated by the priority pointer wins.
  - Assert the winner's rN_ready combinationally in the same cycle. Only one ready is ever high.
  - At the clock edge, latch a, b, op and id, set err if op is 4–6, and go to EXEC.
- EXEC:
  - alu_a/alu_b = latched operands.
  - alu_op = latched op, or 7 if err is set.
  - At the clock edge, capture alu_res and alu_zero into rsp_res and rsp_zero, then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* hold their values.
  - When rsp_ready = 1, at the clock edge: go to IDLE and set the priority pointer to the requester that was not served.
  - If rsp_ready = 0, hold indefinitely with rsp_* stable.
- Outside EXEC: alu_a = alu_b = 0 and alu_op = 7, so the ALU result is 0.
- Illegal opcode handling: response is returned with rsp_res = 0, rsp_zero = 1, rsp_err = 1. The request is never dropped.
- Width: arithmetic is modulo 2^WIDTH, as performed by the ALU. The block does no arithmetic itself.

## Timing
- Reset values:
  - r0_ready = r1_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_res = 0, rsp_zero = 0, rsp_err = 0.
  - busy = 0, alu_a = alu_b = 0, alu_op = 7.
  - Priority pointer = 0, so requester 0 wins the first tie.
- Latency: request accepted at edge T, ALU driven during cycle T..T+1, rsp_valid high from edge T+1 onward (second cycle after acceptance).
- Throughput: at most one transaction per 3 cycles with rsp_ready held at 1.
- Requests are not accepted in EXEC or RESP; rN_ready = 0 there and requesters must hold valid and operands until ready.
- A requester dropping valid before ready is legal; nothing is latched for it.
- Asynchronous reset in EXEC or RESP aborts the transaction immediately: no response, all outputs return to reset values, and the pointer returns to 0.
- Pointer updates only on response handshake, so a stalled RESP does not alter fairness.

## Test plan
- Reset, then r0: a=5, b=3, op=0 → r0_ready in IDLE cycle; two edges later rsp_valid=1, rsp_id=0, rsp_res=8, rsp_zero=0, rsp_err=0.
- r1: a=7, b=7, op=1 → rsp_res=0, rsp_zero=1, rsp_id=1; and a=0xF0, b=0x3C, op=3 → rsp_res=0xFC.
- Both valid continuously with rsp_ready=1 → grants alternate 0,1,0,1 over four transactions, each 3 cycles apart.
- r0 op=5 → alu_op stays 7 during EXEC; rsp_res=0, rsp_zero=1, rsp_err=1.
- rsp_ready=0 for 10 cycles in RESP → rsp_* stable, busy=1, no rN_ready; release → IDLE next edge.
- rst_n pulsed low during EXEC → rsp_valid never rises, all outputs at reset values, next tie granted to r0.
